// File: rtl/onehot_encoder_2buf.sv
// Registered one-hot-to-binary encoder with zero/multi-hot flags, a 2-entry
// output FIFO for bubble-free backpressure, and a saturating malformed-input counter.
module onehot_encoder_2buf #(
  parameter int N_IN      = 4,
  parameter int ERR_CNT_W = 8,
  localparam int W_IDX    = $clog2(N_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W_IDX-1:0]     out_idx,
  output logic                 out_zero,
  output logic                 out_multi,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // state | meaning
  // EMPTY | no buffered entries
  // ONE   | one entry, at the head
  // FULL  | two entries, in_ready low
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

  localparam int ENT_W = W_IDX + 2;

  occ_t             state, next_state;
  logic             rdy_q;
  logic             push, pop;
  logic             wr_ptr, rd_ptr;
  logic [ENT_W-1:0] mem [2];
  logic [ENT_W-1:0] head;
  logic [W_IDX-1:0] enc_idx;
  logic             enc_zero, enc_multi, found;

  always_comb begin
    enc_idx   = '0;
    enc_zero  = (in_vec == '0);
    enc_multi = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_vec[i]) begin
        if (found) begin
          enc_multi = 1'b1;
        end else begin
          enc_idx = W_IDX'(i);
          found   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (push) next_state = ONE;
      ONE:     if (push && !pop) next_state = FULL;
               else if (pop && !push) next_state = EMPTY;
      FULL:    if (pop) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  // rdy_q keeps in_ready low until the first edge after reset release
  always_comb begin
    in_ready  = rdy_q && (state != FULL);
    out_valid = (state != EMPTY);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      mem[0]  <= '0;
      mem[1]  <= '0;
      err_cnt <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= {enc_idx, enc_zero, enc_multi};
        wr_ptr      <= ~wr_ptr;
        if ((enc_zero || enc_multi) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // stale storage is masked so the outputs read zero whenever empty
  assign head      = mem[rd_ptr];
  assign out_idx   = out_valid ? head[ENT_W-1:2] : '0;
  assign out_zero  = out_valid && head[1];
  assign out_multi = out_valid && head[0];

endmodule
